// File: rtl/atom_pkg.sv
// Shared definitions for the memory arbiter: FSM states, grant encoding,
// watchdog sizing and the grant-selection rule.
package atom_pkg;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int WD_WIDTH        = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_e;

  // On contention the requester that did not win last time gets the port.
  function automatic grant_e pick_grant(input logic if_req, input logic d_req,
                                        input grant_e last);
    grant_e g;
    if (if_req && d_req) begin
      if (last == GNT_IF) g = GNT_D;
      else                g = GNT_IF;
    end else if (d_req) begin
      g = GNT_D;
    end else begin
      g = GNT_IF;
    end
    return g;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Transaction watchdog: counts stalled memory cycles since the last clear and
// flags the cycle in which the count reaches TIMEOUT.
module arb_watchdog
  import atom_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [WD_WIDTH-1:0] LAST_COUNT = WD_WIDTH'(TIMEOUT - 1);

  logic [WD_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + WD_WIDTH'(1);
    end
  end

  // The stalled cycle that would bring the count to TIMEOUT is the abort cycle.
  assign expire = enable && (cnt == LAST_COUNT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single external memory port,
// with alternating priority on contention and a per-transaction watchdog.
module mem_arbiter
  import atom_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_ack,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [3:0]      d_be,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_ack,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_err,
  output logic            m_req,
  output logic            m_we,
  output logic [3:0]      m_be,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  input  logic            m_ack,
  input  logic [XLEN-1:0] m_rdata
);

  arb_state_e state_q, state_d;
  grant_e     last_grant, grant;
  logic       do_grant, busy, wd_en, wd_expire;
  logic       finish_ok, finish_to;

  assign busy     = (state_q == BUSY_IF) || (state_q == BUSY_D);
  assign do_grant = (state_q == IDLE) && (if_req || d_req);
  assign grant    = pick_grant(if_req, d_req, last_grant);
  assign wd_en    = busy && !m_ack;

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (do_grant),
    .enable (wd_en),
    .expire (wd_expire)
  );

  // NOTE: every signal written here gets a default first, otherwise paths
  // that skip an assignment infer latches.
  always_comb begin
    state_d   = state_q;
    finish_ok = 1'b0;
    finish_to = 1'b0;
    case (state_q)
      IDLE: begin
        if (do_grant) state_d = (grant == GNT_D) ? BUSY_D : BUSY_IF;
      end
      BUSY_IF, BUSY_D: begin
        // A memory ack wins over a simultaneous watchdog expiry.
        if (m_ack) begin
          finish_ok = 1'b1;
          state_d   = RESP;
        end else if (wd_expire) begin
          finish_to = 1'b1;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_grant <= GNT_IF;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_be       <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      if_ack     <= 1'b0;
      if_err     <= 1'b0;
      if_rdata   <= '0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
    end else begin
      state_q <= state_d;
      if_ack  <= 1'b0;
      if_err  <= 1'b0;
      d_ack   <= 1'b0;
      d_err   <= 1'b0;

      if (do_grant) begin
        last_grant <= grant;
        m_req      <= 1'b1;
        if (grant == GNT_D) begin
          m_addr  <= d_addr;
          m_we    <= d_we;
          m_be    <= d_be;
          m_wdata <= d_wdata;
        end else begin
          m_addr  <= if_addr;
          m_we    <= 1'b0;
          m_be    <= 4'hF;
          m_wdata <= '0;
        end
      end

      if (finish_ok || finish_to) begin
        m_req <= 1'b0;
        if (state_q == BUSY_IF) begin
          if_ack   <= 1'b1;
          if_err   <= finish_to;
          if_rdata <= finish_ok ? m_rdata : '0;
        end else begin
          d_ack <= 1'b1;
          d_err <= finish_to;
          // Completed writes leave the last read value in place.
          if (finish_to)  d_rdata <= '0;
          else if (!m_we) d_rdata <= m_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_mem_arbiter;

  localparam int XLEN = 32;
  localparam int TO   = 16;

  logic            clk, rst_n;
  logic            if_req, if_ack, if_err;
  logic [XLEN-1:0] if_addr, if_rdata;
  logic            d_req, d_we, d_ack, d_err;
  logic [3:0]      d_be;
  logic [XLEN-1:0] d_addr, d_wdata, d_rdata;
  logic            m_req, m_we, m_ack;
  logic [3:0]      m_be;
  logic [XLEN-1:0] m_addr, m_wdata, m_rdata;

  mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: 0 = never acks, 1 = acks resp_delay cycles after m_req rises,
  // 2 = ack held high regardless of m_req.
  int              resp_mode  = 0;
  int              resp_delay = 0;
  logic [XLEN-1:0] mem_rdata  = '0;
  int              resp_cnt   = 0;

  initial begin
    m_ack   = 1'b0;
    m_rdata = '0;
  end

  always @(posedge clk) begin
    #1;
    case (resp_mode)
      1: begin
        if (!m_req) begin
          resp_cnt = 0;
          m_ack    = 1'b0;
        end else begin
          m_ack    = (resp_cnt >= resp_delay);
          resp_cnt = resp_cnt + 1;
        end
      end
      2:       m_ack = 1'b1;
      default: m_ack = 1'b0;
    endcase
    m_rdata = mem_rdata;
  end

  // Reference model: one outstanding transaction owned by fetch (1) or data (2),
  // a response cycle after it ends, and nothing granted during that cycle.
  logic            e_m_req, e_m_we, e_if_ack, e_if_err, e_d_ack, e_d_err;
  logic [3:0]      e_m_be;
  logic [XLEN-1:0] e_m_addr, e_m_wdata, e_if_rdata, e_d_rdata;
  int              owner, waited;
  bit              responding, last_was_d;

  task automatic model_finish(input bit aborted);
    e_m_req    = 1'b0;
    responding = 1'b1;
    if (owner == 1) begin
      e_if_ack   = 1'b1;
      e_if_err   = aborted;
      e_if_rdata = aborted ? '0 : m_rdata;
    end else begin
      e_d_ack = 1'b1;
      e_d_err = aborted;
      if (aborted)      e_d_rdata = '0;
      else if (!e_m_we) e_d_rdata = m_rdata;
    end
    owner = 0;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      {e_m_req, e_m_we, e_if_ack, e_if_err, e_d_ack, e_d_err} = '0;
      e_m_be = '0; e_m_addr = '0; e_m_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
      owner = 0; waited = 0; responding = 0; last_was_d = 0;
    end else begin
      {e_if_ack, e_if_err, e_d_ack, e_d_err} = '0;
      if (responding) begin
        responding = 0;
      end else if (owner != 0) begin
        if (m_ack) model_finish(1'b0);
        else begin
          waited++;
          if (waited == TO) model_finish(1'b1);
        end
      end else if (if_req || d_req) begin
        bit take_d;
        take_d  = d_req && (!if_req || !last_was_d);
        last_was_d = take_d;
        owner   = take_d ? 2 : 1;
        waited  = 0;
        e_m_req = 1'b1;
        e_m_addr  = take_d ? d_addr  : if_addr;
        e_m_we    = take_d ? d_we    : 1'b0;
        e_m_be    = take_d ? d_be    : 4'hF;
        e_m_wdata = take_d ? d_wdata : '0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_req", m_req, e_m_req);
      check("if_ack", if_ack, e_if_ack);
      check("if_err", if_err, e_if_err);
      check("if_rdata", if_rdata, e_if_rdata);
      check("d_ack", d_ack, e_d_ack);
      check("d_err", d_err, e_d_err);
      check("d_rdata", d_rdata, e_d_rdata);
      if (e_m_req) begin
        check("m_addr", m_addr, e_m_addr);
        check("m_we", m_we, e_m_we);
        check("m_be", m_be, e_m_be);
        check("m_wdata", m_wdata, e_m_wdata);
      end
    end
  end

  // Waits (at negedges) for the selected ack; lat counts negedges since the call.
  task automatic wait_ack(input string name, input bit is_d, input int budget,
                          output int lat, output int busy);
    bit seen;
    lat = 0; busy = 0; seen = 0;
    while (!seen && lat < budget) begin
      @(negedge clk);
      lat++;
      if (m_req) busy++;
      seen = is_d ? d_ack : if_ack;
    end
    if (!seen) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_ack_wait: no ack within %0d cycles", name, budget);
    end
  endtask

  int lat, busy, pulses;

  initial begin
    rst_n = 1'b0;
    if_req = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    @(posedge clk); #1;
    cmp_en = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_m_req", m_req, 0);
    check("rst_if_ack", if_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_m_addr", m_addr, 0);
    rst_n = 1'b1;

    // Single fetch with ack in the first BUSY cycle.
    @(negedge clk);
    resp_mode = 1; resp_delay = 0; mem_rdata = 32'h0000_0013;
    if_req = 1; if_addr = 32'h100;
    @(negedge clk);
    check("fetch_m_req", m_req, 1);
    check("fetch_m_addr", m_addr, 32'h100);
    check("fetch_m_we", m_we, 0);
    check("fetch_m_be", m_be, 4'hF);
    @(negedge clk);
    check("fetch_if_ack", if_ack, 1);
    check("fetch_if_rdata", if_rdata, 32'h13);
    check("fetch_if_err", if_err, 0);
    check("fetch_m_req_drop", m_req, 0);
    if_req = 0;
    @(negedge clk);
    check("fetch_ack_single", if_ack, 0);

    // Data read, then a write that must not disturb d_rdata.
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h40; mem_rdata = 32'hCAFE_F00D;
    wait_ack("dread", 1, 10, lat, busy);
    check("dread_lat", lat, 2);
    check("dread_rdata", d_rdata, 32'hCAFE_F00D);
    d_req = 0;
    @(negedge clk);
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
    mem_rdata = 32'h1111_1111;
    @(negedge clk);
    check("dwr_m_we", m_we, 1);
    check("dwr_m_be", m_be, 4'b0011);
    check("dwr_m_addr", m_addr, 32'h2000);
    check("dwr_m_wdata", m_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("dwr_d_ack", d_ack, 1);
    check("dwr_d_rdata_kept", d_rdata, 32'hCAFE_F00D);
    d_req = 0; d_we = 0;
    @(negedge clk);

    // Memory never answers: abort after TIMEOUT busy cycles.
    resp_mode = 0;
    d_req = 1; d_addr = 32'h500;
    wait_ack("tmo", 1, 40, lat, busy);
    check("tmo_lat", lat, 17);
    check("tmo_busy_cycles", busy, 16);
    check("tmo_m_req", m_req, 0);
    check("tmo_d_err", d_err, 1);
    check("tmo_d_rdata", d_rdata, 0);
    d_req = 0;
    @(negedge clk);
    check("tmo_err_pulse", d_err, 0);

    // Ack on the expiry cycle completes normally.
    resp_mode = 1; resp_delay = 15; mem_rdata = 32'h1234_5678;
    d_req = 1; d_addr = 32'h504;
    wait_ack("edge", 1, 40, lat, busy);
    check("edge_lat", lat, 17);
    check("edge_d_err", d_err, 0);
    check("edge_d_rdata", d_rdata, 32'h1234_5678);
    d_req = 0;
    @(negedge clk);

    // m_ack held high while idle is ignored.
    resp_mode = 2;
    repeat (3) begin
      @(negedge clk);
      check("idle_ack_m_req", m_req, 0);
      check("idle_ack_if_ack", if_ack, 0);
    end
    if_req = 1; if_addr = 32'h80; mem_rdata = 32'h0BAD_F00D;
    wait_ack("stuck", 0, 10, lat, busy);
    check("stuck_lat", lat, 2);
    check("stuck_rdata", if_rdata, 32'h0BAD_F00D);
    if_req = 0;
    resp_mode = 1; resp_delay = 3;
    @(negedge clk);

    // Data requester withdraws mid-transaction.
    d_req = 1; d_addr = 32'h700; mem_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    d_req = 0; d_addr = 32'hFFFF_0000;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (d_ack) begin
        pulses++;
        check("drop_ack_cycle", i, 3);
      end
    end
    check("drop_ack_pulses", pulses, 1);
    check("drop_rdata", d_rdata, 32'hA5A5_A5A5);

    // Last grant was data, so fetch wins this contention.
    resp_delay = 0;
    if_req = 1; if_addr = 32'h900; d_req = 1; d_addr = 32'h904; d_we = 0;
    @(negedge clk);
    check("alt_first_if", m_addr, 32'h900);
    wait_ack("alt_if", 0, 10, lat, busy);
    if_req = 0;
    wait_ack("alt_d", 1, 10, lat, busy);
    check("alt_d_lat", lat, 3);
    d_req = 0;
    @(negedge clk);

    // Reset during a fetch: no ack, then normal service.
    resp_mode = 0;
    if_req = 1; if_addr = 32'h600;
    @(negedge clk);
    check("rmid_busy", m_req, 1);
    rst_n = 0; if_req = 0;
    @(negedge clk);
    check("rmid_m_req", m_req, 0);
    check("rmid_if_ack", if_ack, 0);
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      check("rmid_no_ack", if_ack, 0);
    end
    resp_mode = 1; resp_delay = 0; mem_rdata = 32'h600D_CAFE;
    if_req = 1; if_addr = 32'h604;
    wait_ack("rmid_new", 0, 10, lat, busy);
    check("rmid_new_lat", lat, 2);
    check("rmid_new_rdata", if_rdata, 32'h600D_CAFE);
    if_req = 0;
    @(negedge clk);

    // Contention straight out of reset: D, IF, D, IF every 3 cycles.
    rst_n = 0;
    @(negedge clk);
    rst_n = 1; if_req = 1; if_addr = 32'h300; d_req = 1; d_addr = 32'h400;
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      check($sformatf("cont_d_ack_c%0d", j), d_ack, (j == 2 || j == 8));
      check($sformatf("cont_if_ack_c%0d", j), if_ack, (j == 5 || j == 11));
      if (j == 1 || j == 7) check($sformatf("cont_grant_d_c%0d", j), m_addr, 32'h400);
      if (j == 4 || j == 10) check($sformatf("cont_grant_if_c%0d", j), m_addr, 32'h300);
    end
    if_req = 0; d_req = 0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
